// File: rtl/fifo_ext.sv
// Single-clock FIFO with normal/show-ahead read, fill level, almost flags,
// overflow/underflow pulses and synchronous clear.
module fifo_ext #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BIT  = 2,
  parameter int unsigned SHOWAHEAD  = 0,
  parameter int unsigned AFULL_LVL  = (1 << DEPTH_BIT) - 1,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 srst_i,
  input  logic                 wr_req_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_req_i,
  output logic [WIDTH-1:0]     rd_data_o,
  output logic                 rd_valid_o,
  output logic [DEPTH_BIT:0]   usedw_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_BIT;
  localparam int unsigned PW    = DEPTH_BIT + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, usedw_n;
  logic [DEPTH_BIT-1:0] wr_addr, rd_addr;
  logic                 wr_acc, rd_acc;
  logic [WIDTH-1:0]     rd_data_q;
  logic                 rd_valid_q;

  assign wr_addr = wr_ptr[DEPTH_BIT-1:0];
  assign rd_addr = rd_ptr[DEPTH_BIT-1:0];

  // Acceptance uses the registered (pre-edge) flags; clear blocks both sides.
  assign wr_acc = wr_req_i && !full_o  && !srst_i;
  assign rd_acc = rd_req_i && !empty_o && !srst_i;

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (srst_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end else begin
      if (wr_acc) wr_ptr_n = wr_ptr + PW'(1);
      if (rd_acc) rd_ptr_n = rd_ptr + PW'(1);
    end
    usedw_n = wr_ptr_n - rd_ptr_n;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      usedw_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      usedw_o        <= usedw_n;
      full_o         <= (usedw_n == PW'(DEPTH));
      empty_o        <= (wr_ptr_n == rd_ptr_n);
      almost_full_o  <= (usedw_n >= PW'(AFULL_LVL));
      almost_empty_o <= (usedw_n <= PW'(AEMPTY_LVL));
      overflow_o     <= wr_req_i && full_o  && !srst_i;
      underflow_o    <= rd_req_i && empty_o && !srst_i;
      rd_valid_q     <= rd_acc;
      if (srst_i)      rd_data_q <= '0;
      else if (rd_acc) rd_data_q <= mem[rd_addr];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_addr] <= wr_data_i;
  end

  // Show-ahead presents the head word combinationally from storage.
  assign rd_data_o  = (SHOWAHEAD != 0) ? (empty_o ? '0 : mem[rd_addr]) : rd_data_q;
  assign rd_valid_o = (SHOWAHEAD != 0) ? !empty_o : rd_valid_q;

endmodule

// File: doc/fifo_ext.md
Name: fifo_ext

Overview:
- Parametrised synchronous single-clock FIFO; successor to the team's basic FIFO.
- Adds:
  - selectable normal / show-ahead read mode
  - fill-level count output
  - programmable almost-full / almost-empty flags
  - overflow / underflow error pulses
  - synchronous clear
- Sits between streaming producers and consumers inside one clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH_BIT, 2, log2 of storage depth; DEPTH = 2**DEPTH_BIT words.
- SHOWAHEAD, 0, 0 = normal registered read; 1 = head word presented on rd_data_o without a request.
- AFULL_LVL, 2**DEPTH_BIT-1, almost_full_o asserts when usedw_o >= AFULL_LVL.
- AEMPTY_LVL, 1, almost_empty_o asserts when usedw_o <= AEMPTY_LVL.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- srst_i  in  1  synchronous clear, active-high.
- wr_req_i  in  1  write request.
- wr_data_i  in  WIDTH  write data.
- rd_req_i  in  1  read request (normal mode) / head acknowledge (show-ahead).
- rd_data_o  out  WIDTH  read data.
- rd_valid_o  out  1  rd_data_o carries a newly read word (normal mode); equals !empty_o in show-ahead.
- usedw_o  out  DEPTH_BIT+1  number of stored words, 0..DEPTH.
- full_o  out  1  usedw_o == DEPTH.
- empty_o  out  1  usedw_o == 0.
- almost_full_o  out  1  usedw_o >= AFULL_LVL.
- almost_empty_o  out  1  usedw_o <= AEMPTY_LVL.
- overflow_o  out  1  one-cycle error pulse: rejected write.
- underflow_o  out  1  one-cycle error pulse: rejected read.

Behaviour:
- Reset (rst_n_i low, asynchronous): pointers 0, usedw_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, rd_data_o 0, rd_valid_o 0, overflow_o 0, underflow_o 0. Memory contents are not reset.
- Reset mid-operation: all stored words are discarded immediately; first write after release lands at address 0.
- srst_i high at an edge: same state as reset at that edge, memory untouched. Overrides wr_req_i/rd_req_i in that cycle; no overflow/underflow pulse.
- Pointers: DEPTH_BIT+1 bits, MSB is wrap bit.
  - full: low bits equal, MSB differs.
  - empty: pointers equal.
  - Natural wrap from 2**(DEPTH_BIT+1)-1 to 0.
- Write accepted iff wr_req_i && !full_o: word stored at wr_ptr, wr_ptr+1. Unaccepted writes never modify memory.
- Read accepted iff rd_req_i && !empty_o: rd_ptr+1.
- Flags are evaluated on pre-edge state:
  - Simultaneous request when full: read accepted, write rejected, overflow_o pulses.
  - Simultaneous request when empty: write accepted, read rejected, underflow_o pulses.
  - Otherwise simultaneous accept: usedw_o unchanged.
- usedw_o, full_o, empty_o, almost_* are registered and update on the edge after the accepting cycle.
- Normal mode (SHOWAHEAD=0):
  - Accepted read loads mem[rd_ptr] into rd_data_o; rd_valid_o is 1 for exactly the following cycle (latency 1).
  - rd_data_o holds its last value otherwise.
- Show-ahead mode (SHOWAHEAD=1):
  - rd_data_o = mem[rd_ptr] continuously while !empty_o; rd_req_i pops the head.
  - A word written into an empty FIFO is visible one cycle after the write edge.
  - rd_data_o is don't-care while empty_o = 1.
- overflow_o / underflow_o: registered, asserted for the cycle after the offending request edge. Level-high requests give a pulse per rejected cycle.
- Parameters must satisfy AEMPTY_LVL < AFULL_LVL <= DEPTH; behaviour is undefined otherwise.

Test Plan (WIDTH=8, DEPTH_BIT=2, AFULL_LVL=3, AEMPTY_LVL=1):
1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> usedw_o 1,2,3,4; almost_empty_o drops after 2nd word; almost_full_o rises after 3rd; full_o=1 after 4th.
2. Full FIFO, write 0x55 -> overflow_o pulses once, usedw_o stays 4. Read 4 (SHOWAHEAD=0) -> rd_data_o 0x11,0x22,0x33,0x44 each 1 cycle after request with rd_valid_o=1; empty_o=1 after last.
3. Empty FIFO, rd_req_i and wr_req_i (0xA5) same cycle -> underflow_o pulses, usedw_o=1, next read returns 0xA5.
4. Wrap: 10 alternating write/read pairs with data 0..9 -> data returned in order, usedw_o never exceeds 1; pointers wrap past 7 with no false full_o.
5. SHOWAHEAD=1: write 0x3C to empty -> rd_data_o=0x3C, empty_o=0 one cycle later without rd_req_i; rd_req_i -> empty_o=1 next cycle.
6. With 3 words stored, assert srst_i together with wr_req_i -> usedw_o=0, empty_o=1, no overflow pulse. Separately, drop rst_n_i mid-burst -> all outputs at reset values without a clock edge.
